// File: rtl/mem_pkg.sv
// Shared encodings for the data memory controller: access sizes, fault codes, FSM states,
// plus the load lane-extraction helper.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_SIZE     = 2'b11;

    typedef enum logic {
        INIT,
        RUN
    } mem_state_e;

    // Pick the addressed lane(s) out of a little-endian word and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic sext);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            MEM_BYTE: return {{24{sext & shifted[7]}}, shifted[7:0]};
            MEM_HALF: return {{16{sext & shifted[15]}}, shifted[15:0]};
            default:  return word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Word-wide storage with a byte-enable write port, a clear-write port and one
// combinational read port.
module data_mem_ram #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [3:0]       wr_be,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked byte-addressable data memory: fault checks, store lane steering, load
// extension, post-reset clear sequencer and a fixed-latency in-order response pipeline.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DEPTH_BYTES    = 1024,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_fault,
    output logic                  init_busy
);

    localparam int unsigned WORDS  = DEPTH_BYTES / 4;
    localparam int unsigned IDX_W  = $clog2(WORDS);
    localparam int unsigned BYTE_W = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_ADDR = ADDR_WIDTH'(DEPTH_BYTES);

    mem_state_e       state_q;
    logic [IDX_W-1:0] clr_cnt_q;
    logic             ready_q;
    logic             busy_q;

    logic             accept;
    logic             out_of_range;
    logic             clr_en;
    logic             wr_en;
    logic [1:0]       lane;
    logic [1:0]       fault;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [IDX_W-1:0] word_idx;

    logic [READ_LATENCY-1:0] pv_q;
    logic [31:0]             pd_q [READ_LATENCY];
    logic [1:0]              pf_q [READ_LATENCY];

    assign lane         = req_addr[1:0];
    assign word_idx     = req_addr[BYTE_W-1:2];
    assign out_of_range = req_addr >= DEPTH_ADDR;
    // rst is gated in so a request presented during a mid-flight reset never commits.
    assign accept       = req_valid & ready_q & ~rst;
    assign clr_en       = (state_q == INIT) & ~rst;
    assign wr_en        = accept & req_wr & (fault == FLT_NONE);

    always_comb begin
        fault = FLT_NONE;
        if (req_size == FLT_SIZE) begin
            fault = FLT_SIZE;
        end else if (out_of_range) begin
            fault = FLT_RANGE;
        end else if ((req_size == MEM_HALF && lane[0]) ||
                     (req_size == MEM_WORD && lane != 2'b00)) begin
            fault = FLT_MISALIGN;
        end
    end

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
        case (req_size)
            MEM_BYTE: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_wdata[7:0]}};
            end
            MEM_HALF: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
        endcase
    end

    data_mem_ram #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_be   (wr_be),
        .wr_idx  (word_idx),
        .wr_data (wr_data),
        .clr_en  (clr_en),
        .clr_idx (clr_cnt_q),
        .rd_idx  (word_idx),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? INIT : RUN;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= CLEAR_ON_RESET;
        end else begin
            case (state_q)
                INIT: begin
                    if (clr_cnt_q == IDX_W'(WORDS - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Response pipeline; bubbles carry zero data so idle stages never leak stale results.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pd_q[i] <= '0;
                pf_q[i] <= FLT_NONE;
            end
        end else begin
            pv_q[0] <= accept;
            pd_q[0] <= (accept && !req_wr && fault == FLT_NONE) ?
                       load_extend(rd_word, lane, req_size, req_sext) : '0;
            pf_q[0] <= accept ? fault : FLT_NONE;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
                pf_q[i] <= pf_q[i-1];
            end
        end
    end

    assign req_ready = ready_q;
    assign init_busy = busy_q;
    assign rsp_valid = pv_q[READ_LATENCY-1];
    assign rsp_rdata = pd_q[READ_LATENCY-1];
    assign rsp_fault = pf_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random traffic, all
// scored against a byte-array reference model with a queue of timed expected responses.
module tb_data_mem_ctrl;

    localparam int L     = 4;
    localparam int DEPTH = 1024;
    localparam int WORDS = DEPTH / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sext = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;
    logic        init_busy;

    data_mem_ctrl #(
        .ADDR_WIDTH     (32),
        .DEPTH_BYTES    (DEPTH),
        .READ_LATENCY   (L),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  flt;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [7:0]  mm [DEPTH];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          init_left = 0;
    int          rsp_cnt = 0;
    bit          ready_exp = 1'b0;
    logic [31:0] last_data = '0;
    logic [1:0]  last_fault = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs presented before it.
    task automatic model_edge();
        int          a;
        logic [1:0]  f;
        logic [31:0] d;
        rsp_t        r;
        cyc++;
        if (rst) begin
            exp_q.delete();
            ready_exp = 1'b0;
            init_left = WORDS;
            for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
            return;
        end
        if (req_valid && ready_exp) begin
            if (req_size == 2'b11)                            f = 2'b11;
            else if (req_addr >= DEPTH)                       f = 2'b10;
            else if ((req_size == 2'b01 && req_addr % 2 != 0) ||
                     (req_size == 2'b10 && req_addr % 4 != 0)) f = 2'b01;
            else                                              f = 2'b00;
            d = '0;
            if (f == 2'b00) begin
                a = int'(req_addr);
                if (req_wr) begin
                    mm[a] = req_wdata[7:0];
                    if (req_size != 2'b00) mm[a+1] = req_wdata[15:8];
                    if (req_size == 2'b10) begin
                        mm[a+2] = req_wdata[23:16];
                        mm[a+3] = req_wdata[31:24];
                    end
                end else if (req_size == 2'b00) begin
                    d = {24'h0, mm[a]};
                    if (req_sext && mm[a][7]) d = d | 32'hFFFF_FF00;
                end else if (req_size == 2'b01) begin
                    d = {16'h0, mm[a+1], mm[a]};
                    if (req_sext && mm[a+1][7]) d = d | 32'hFFFF_0000;
                end else begin
                    d = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
                end
            end
            r.due  = cyc + L - 1;
            r.data = d;
            r.flt  = f;
            exp_q.push_back(r);
        end
        if (init_left > 0) begin
            init_left--;
            if (init_left == 0) ready_exp = 1'b1;
        end
    endtask

    task automatic cycle();
        bit ev;
        @(posedge clk);
        model_edge();
        #1;
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            check("rsp_rdata", rsp_rdata, exp_q[0].data);
            check("rsp_fault", 32'(rsp_fault), 32'(exp_q[0].flt));
            void'(exp_q.pop_front());
        end
        if (rsp_valid) begin
            rsp_cnt++;
            last_data  = rsp_rdata;
            last_fault = rsp_fault;
        end
        check("req_ready", 32'(req_ready), 32'(ready_exp));
        check("init_busy", 32'(init_busy), 32'(init_left > 0));
    endtask

    task automatic set_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic sext);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_sext  = sext;
    endtask

    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sext,
                       input logic [31:0] exp_d, input logic [1:0] exp_f);
        int n0;
        n0 = rsp_cnt;
        set_req(wr, addr, wdata, size, sext);
        cycle();
        req_valid = 1'b0;
        repeat (L) cycle();
        check({tag, "_cnt"}, 32'(rsp_cnt - n0), 32'd1);
        check({tag, "_data"}, last_data, exp_d);
        check({tag, "_flt"}, 32'(last_fault), 32'(exp_f));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 400) begin
            cycle();
            n++;
        end
        check(tag, 32'(n), 32'(WORDS));
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        wait_ready("init_cycles");
        txn("ld_3fc", 1'b0, 32'h3FC, '0, 2'b10, 1'b0, 32'h0, 2'b00);

        // Widths and extension.
        txn("st_10", 1'b1, 32'h10, 32'h8899_AABC, 2'b10, 1'b0, 32'h0, 2'b00);
        txn("ldb_10", 1'b0, 32'h10, '0, 2'b00, 1'b1, 32'hFFFF_FFBC, 2'b00);
        txn("ldh_12", 1'b0, 32'h12, '0, 2'b01, 1'b0, 32'h0000_8899, 2'b00);
        txn("ldw_10", 1'b0, 32'h10, '0, 2'b10, 1'b0, 32'h8899_AABC, 2'b00);

        // Byte merge with back-to-back read-after-write.
        txn("st_20", 1'b1, 32'h20, 32'h1122_3344, 2'b10, 1'b0, 32'h0, 2'b00);
        set_req(1'b1, 32'h21, 32'h0000_00EE, 2'b00, 1'b0);
        cycle();
        set_req(1'b0, 32'h20, '0, 2'b10, 1'b0);
        cycle();
        req_valid = 1'b0;
        repeat (L) cycle();
        check("raw_merge", last_data, 32'h1122_EE44);

        // Faults.
        txn("flt_mis", 1'b0, 32'h13, '0, 2'b01, 1'b0, 32'h0, 2'b01);
        txn("flt_rng", 1'b1, 32'h400, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 2'b10);
        txn("ld_0", 1'b0, 32'h0, '0, 2'b10, 1'b0, 32'h0, 2'b00);
        txn("flt_size", 1'b0, 32'h401, '0, 2'b11, 1'b0, 32'h0, 2'b11);

        // Eight back-to-back loads, two bubbles, one store.
        n0 = rsp_cnt;
        for (int i = 0; i < 8; i++) begin
            set_req(1'b0, 32'h10 + 32'(i), '0, 2'b00, i[0]);
            cycle();
        end
        req_valid = 1'b0;
        repeat (2) cycle();
        set_req(1'b1, 32'h30, 32'hCAFE_F00D, 2'b10, 1'b0);
        cycle();
        req_valid = 1'b0;
        repeat (L) cycle();
        check("b2b_cnt", 32'(rsp_cnt - n0), 32'd9);

        // Reset with loads in flight.
        txn("st_40", 1'b1, 32'h40, 32'h5A5A_5A5A, 2'b10, 1'b0, 32'h0, 2'b00);
        n0 = rsp_cnt;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, 32'h40, '0, 2'b10, 1'b0);
            cycle();
        end
        req_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wait_ready("reinit_cycles");
        check("flushed_cnt", 32'(rsp_cnt - n0), 32'd0);
        txn("ld_40", 1'b0, 32'h40, '0, 2'b10, 1'b0, 32'h0, 2'b00);

        // Random traffic, mostly in range and aligned.
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = 32'($urandom_range(0, 1100));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) ad[0] = 1'b0;
                if (sz == 2'b10) ad[1:0] = 2'b00;
            end
            set_req(1'($urandom_range(0, 1)), ad, $urandom, sz, 1'($urandom_range(0, 1)));
            req_valid = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = 1'b0;
        repeat (L + 1) cycle();
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
